// File: rtl/alu_defs.sv
// alu_defs: shared ALU opcodes, MIPS opcode/funct encodings and issue-stage types
package alu_defs;
  localparam logic [3:0] ALU_NONE = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_SLT  = 4'h3;
  localparam logic [3:0] ALU_SLTU = 4'h4;
  localparam logic [3:0] ALU_AND  = 4'h5;
  localparam logic [3:0] ALU_NOR  = 4'h6;
  localparam logic [3:0] ALU_OR   = 4'h7;
  localparam logic [3:0] ALU_XOR  = 4'h8;
  localparam logic [3:0] ALU_SLL  = 4'h9;
  localparam logic [3:0] ALU_SRL  = 4'hA;
  localparam logic [3:0] ALU_SRA  = 4'hB;
  localparam logic [3:0] ALU_LUI  = 4'hC;
  localparam logic [3:0] ALU_XNOR = 4'hD;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  localparam logic [5:0] FN_XNOR = 6'h3F;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} stage_state_t;

  typedef struct packed {
    logic [3:0]  control;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dest;
    logic        wen;
    logic        illegal;
    logic [31:0] pc;
  } issue_t;
endpackage

// File: rtl/alu_inst_decode.sv
// alu_inst_decode: combinational decode of ALU-class MIPS instructions into op code and operands
module alu_inst_decode
  import alu_defs::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  output logic [3:0]  control,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic [4:0]  dest,
  output logic        wen,
  output logic        illegal
);
  logic [5:0] op, fn;
  logic [15:0] imm;
  logic unused_rs;
  assign op = inst[31:26];
  assign fn = inst[5:0];
  assign imm = inst[15:0];
  assign unused_rs = ^inst[25:21];
  always_comb begin
    control = ALU_NONE;
    src1 = '0;
    src2 = '0;
    dest = '0;
    if (op == OP_SPECIAL) begin
      case (fn)
        FN_SLL, FN_SLLV: control = ALU_SLL;
        FN_SRL, FN_SRLV: control = ALU_SRL;
        FN_SRA, FN_SRAV: control = ALU_SRA;
        FN_ADDU:         control = ALU_ADD;
        FN_SUBU:         control = ALU_SUB;
        FN_AND:          control = ALU_AND;
        FN_OR:           control = ALU_OR;
        FN_XOR:          control = ALU_XOR;
        FN_NOR:          control = ALU_NOR;
        FN_SLT:          control = ALU_SLT;
        FN_SLTU:         control = ALU_SLTU;
        FN_XNOR:         control = ALU_XNOR;
        default:         control = ALU_NONE;
      endcase
      illegal = control == ALU_NONE;
      if (!illegal) begin
        src1 = (fn inside {FN_SLL, FN_SRL, FN_SRA}) ? {27'd0, inst[10:6]} : rs_value;
        src2 = rt_value;
        dest = inst[15:11];
      end
    end else begin
      case (op)
        OP_ADDIU: control = ALU_ADD;
        OP_SLTI:  control = ALU_SLT;
        OP_SLTIU: control = ALU_SLTU;
        OP_ANDI:  control = ALU_AND;
        OP_ORI:   control = ALU_OR;
        OP_XORI:  control = ALU_XOR;
        OP_LUI:   control = ALU_LUI;
        default:  control = ALU_NONE;
      endcase
      illegal = control == ALU_NONE;
      if (!illegal) begin
        src1 = (op == OP_LUI) ? '0 : rs_value;
        src2 = (op inside {OP_ADDIU, OP_SLTI, OP_SLTIU}) ? {{16{imm[15]}}, imm} : {16'd0, imm};
        dest = inst[20:16];
      end
    end
    wen = !illegal && dest != '0;
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registers decoded ALU operations behind a valid/ready skid buffer
module alu_issue_stage
  import alu_defs::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_inst,
  input  logic [31:0]        in_pc,
  input  logic [31:0]        in_rs_value,
  input  logic [31:0]        in_rt_value,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         alu_control,
  output logic [31:0]        alu_src1,
  output logic [31:0]        alu_src2,
  output logic [4:0]         out_dest,
  output logic               out_wen,
  output logic               out_illegal,
  output logic [31:0]        out_pc,
  output logic [COUNT_W-1:0] issue_count
);
  stage_state_t state_q, state_d;
  issue_t dec, main_q, main_d, skid_q, skid_d;
  logic in_ready_q, in_ready_d;
  logic [COUNT_W-1:0] issue_count_q, issue_count_d;
  logic accept, drain;

  alu_inst_decode u_decode (
    .inst     (in_inst),
    .rs_value (in_rs_value),
    .rt_value (in_rt_value),
    .control  (dec.control),
    .src1     (dec.src1),
    .src2     (dec.src2),
    .dest     (dec.dest),
    .wen      (dec.wen),
    .illegal  (dec.illegal)
  );
  assign dec.pc = in_pc;

  assign accept = in_valid && in_ready_q;
  assign drain = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      S_EMPTY: if (accept) begin
        main_d = dec;
        state_d = S_ONE;
      end
      S_ONE: if (accept && drain) main_d = dec;
        else if (accept) begin
          skid_d = dec;
          state_d = S_TWO;
        end else if (drain) state_d = S_EMPTY;
      S_TWO: if (drain) begin
        main_d = skid_q;
        state_d = S_ONE;
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
    in_ready_d = state_d != S_TWO;
    issue_count_d = issue_count_q + COUNT_W'(drain);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_EMPTY;
      main_q <= '0;
      skid_q <= '0;
      in_ready_q <= 1'b1;
      issue_count_q <= '0;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
      in_ready_q <= in_ready_d;
      issue_count_q <= issue_count_d;
    end

  assign in_ready = in_ready_q;
  assign out_valid = state_q != S_EMPTY;
  assign alu_control = main_q.control;
  assign alu_src1 = main_q.src1;
  assign alu_src2 = main_q.src2;
  assign out_dest = main_q.dest;
  assign out_wen = main_q.wen;
  assign out_illegal = main_q.illegal;
  assign out_pc = main_q.pc;
  assign issue_count = issue_count_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors against a queue-level reference model of the issue stage
module tb_alu_issue_stage;
  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  d;
    logic        w;
    logic        il;
    logic [31:0] pc;
  } exp_t;

  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_inst = 0, in_pc = 0, in_rs_value = 0, in_rt_value = 0;
  logic in_ready, out_valid, out_wen, out_illegal;
  logic [3:0] alu_control;
  logic [31:0] alu_src1, alu_src2, out_pc, issue_count;
  logic [4:0] out_dest;
  int checks = 0, failures = 0;
  exp_t mq[$];
  int unsigned m_cnt = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;
  bit m_drain, m_acc;
  exp_t pin;

  alu_issue_stage #(.COUNT_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_rs_value(in_rs_value), .in_rt_value(in_rt_value),
    .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .out_dest(out_dest), .out_wen(out_wen),
    .out_illegal(out_illegal), .out_pc(out_pc), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t ref_decode(logic [31:0] i, logic [31:0] rsv, logic [31:0] rtv, logic [31:0] pc);
    exp_t e;
    int op, fn;
    e = '0;
    e.pc = pc;
    e.il = 1;
    op = int'(i[31:26]);
    fn = int'(i[5:0]);
    if (op == 0) begin
      case (fn)
        'h00, 'h04: e.c = 9;
        'h02, 'h06: e.c = 10;
        'h03, 'h07: e.c = 11;
        'h21: e.c = 1;
        'h23: e.c = 2;
        'h24: e.c = 5;
        'h25: e.c = 7;
        'h26: e.c = 8;
        'h27: e.c = 6;
        'h2A: e.c = 3;
        'h2B: e.c = 4;
        'h3F: e.c = 13;
        default: e.c = 0;
      endcase
      if (e.c != 0) begin
        e.il = 0;
        e.s1 = (fn < 4) ? {27'd0, i[10:6]} : rsv;
        e.s2 = rtv;
        e.d = i[15:11];
      end
    end else if (op >= 9 && op <= 15) begin
      e.il = 0;
      e.c = (op == 9) ? 4'd1 : (op == 10) ? 4'd3 : (op == 11) ? 4'd4 : (op == 12) ? 4'd5 :
            (op == 13) ? 4'd7 : (op == 14) ? 4'd8 : 4'd12;
      e.s1 = (op == 15) ? 32'd0 : rsv;
      e.s2 = (op <= 11) ? {{16{i[15]}}, i[15:0]} : {16'd0, i[15:0]};
      e.d = i[20:16];
    end
    e.w = !e.il && e.d != 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of at most two decoded entries; ready means room before the edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      m_drain = mq.size() > 0 && out_ready;
      m_acc = in_valid && mq.size() < 2;
      if (m_drain) begin
        void'(mq.pop_front());
        m_cnt++;
      end
      if (flush) mq.delete();
      else if (m_acc) mq.push_back(ref_decode(in_inst, in_rs_value, in_rt_value, in_pc));
    end
  end

  always @(negedge clk) begin
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
    chk("issue_count", issue_count, m_cnt);
    if (mq.size() > 0) begin
      chk("alu_control", {28'd0, alu_control}, {28'd0, mq[0].c});
      chk("alu_src1", alu_src1, mq[0].s1);
      chk("alu_src2", alu_src2, mq[0].s2);
      chk("out_dest", {27'd0, out_dest}, {27'd0, mq[0].d});
      chk("out_wen", {31'd0, out_wen}, {31'd0, mq[0].w});
      chk("out_illegal", {31'd0, out_illegal}, {31'd0, mq[0].il});
      chk("out_pc", out_pc, mq[0].pc);
    end
  end

  task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt,
                     input logic rdy, input logic fl);
    in_valid = v;
    in_inst = inst;
    in_rs_value = rs;
    in_rt_value = rt;
    in_pc = pc_ctr;
    out_ready = rdy;
    flush = fl;
    pc_ctr += 4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    pin = ref_decode(32'h2488FFFF, 32'd5, 32'd0, 32'd0);
    chk("pin_addiu_ctrl", {28'd0, pin.c}, 32'h1);
    chk("pin_addiu_src2", pin.s2, 32'hFFFFFFFF);
    pin = ref_decode(32'h000A4900, 32'd0, 32'h80000001, 32'd0);
    chk("pin_sll_src1", pin.s1, 32'h4);
    chk("pin_sll_dest", {27'd0, pin.d}, 32'd9);
    pin = ref_decode(32'hFC000000, 32'd7, 32'd7, 32'd0);
    chk("pin_illegal", {31'd0, pin.il}, 32'd1);

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_issue_count", issue_count, 32'd0);
    reset = 0;

    cyc(1, 32'h2488FFFF, 32'd5, 32'd0, 1, 0);
    chk("addiu_ctrl", {28'd0, alu_control}, 32'h1);
    chk("addiu_src1", alu_src1, 32'd5);
    chk("addiu_src2", alu_src2, 32'hFFFFFFFF);
    chk("addiu_dest", {27'd0, out_dest}, 32'd8);
    chk("addiu_wen", {30'd0, out_wen, out_illegal}, 32'b10);
    cyc(1, 32'h000A4900, 32'd0, 32'h80000001, 1, 0);
    chk("sll_ctrl", {28'd0, alu_control}, 32'h9);
    chk("sll_src1", alu_src1, 32'h4);
    chk("sll_src2", alu_src2, 32'h80000001);
    chk("sll_dest", {27'd0, out_dest}, 32'd9);
    cyc(1, 32'h3C011234, 32'hDEADBEEF, 32'd0, 1, 0);
    chk("lui_ctrl", {28'd0, alu_control}, 32'hC);
    chk("lui_src1", alu_src1, 32'd0);
    chk("lui_src2", alu_src2, 32'h00001234);
    chk("lui_dest", {27'd0, out_dest}, 32'd1);
    cyc(1, 32'h3082FFFF, 32'h12345678, 32'd0, 1, 0);
    chk("andi_ctrl", {28'd0, alu_control}, 32'h5);
    chk("andi_src2", alu_src2, 32'h0000FFFF);
    chk("andi_dest", {27'd0, out_dest}, 32'd2);
    cyc(1, 32'hFC000000, 32'h11111111, 32'h22222222, 1, 0);
    chk("ill_flags", {30'd0, out_illegal, out_wen}, 32'b10);
    chk("ill_ctrl", {28'd0, alu_control}, 32'h0);
    chk("ill_dest", {27'd0, out_dest}, 32'd0);
    cyc(1, 32'h00000021, 32'd3, 32'd4, 1, 0);
    chk("addu_rd0_ctrl", {28'd0, alu_control}, 32'h1);
    chk("addu_rd0_wen", {31'd0, out_wen}, 32'd0);
    cyc(1, 32'h00A41807, 32'h0000001F, 32'hF0000000, 1, 0);
    cyc(1, 32'h2885FFF6, 32'hFFFFFFF0, 32'd0, 1, 0);
    cyc(1, 32'h0085303F, 32'hAAAA5555, 32'h0F0F0F0F, 1, 0);
    cyc(1, 32'h00000001, 32'd9, 32'd9, 1, 0);
    cyc(0, 32'd0, 32'd0, 32'd0, 1, 0);
    chk("count_after_ten", issue_count, 32'd10);

    cyc(1, 32'h24010001, 32'd0, 32'd0, 0, 0);
    chk("bp_a_in_ready", {31'd0, in_ready}, 32'd1);
    cyc(1, 32'h24020002, 32'd0, 32'd0, 0, 0);
    chk("bp_b_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_a", alu_src2, 32'd1);
    cyc(1, 32'h24030003, 32'd0, 32'd0, 0, 0);
    chk("bp_c_blocked", {31'd0, in_ready}, 32'd0);
    chk("bp_still_a", alu_src2, 32'd1);
    cyc(1, 32'h24030003, 32'd0, 32'd0, 1, 0);
    chk("bp_out_b", alu_src2, 32'd2);
    cyc(1, 32'h24030003, 32'd0, 32'd0, 1, 0);
    chk("bp_out_c", alu_src2, 32'd3);
    cyc(0, 32'd0, 32'd0, 32'd0, 1, 0);
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    chk("bp_count", issue_count, 32'd13);

    cyc(1, 32'h24040004, 32'd0, 32'd0, 0, 0);
    cyc(1, 32'h24050005, 32'd0, 32'd0, 0, 0);
    cyc(1, 32'h24060006, 32'd0, 32'd0, 0, 1);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    cyc(1, 32'h24070007, 32'd0, 32'd0, 0, 0);
    cyc(1, 32'h24080008, 32'd0, 32'd0, 1, 1);
    chk("flush_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_hs_count", issue_count, 32'd14);

    cyc(1, 32'h24090009, 32'd0, 32'd0, 0, 0);
    cyc(1, 32'h240A000A, 32'd0, 32'd0, 0, 0);
    #3 reset = 1;
    #1;
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_count", issue_count, 32'd0);
    chk("async_ready", {31'd0, in_ready}, 32'd1);
    chk("async_ctrl_src", {28'd0, alu_control} | alu_src1 | alu_src2 | out_pc, 32'd0);
    @(posedge clk);
    #1 reset = 0;
    cyc(1, 32'h01095023, 32'd100, 32'd30, 1, 0);
    cyc(0, 32'd0, 32'd0, 32'd0, 1, 0);
    chk("post_reset_count", issue_count, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
